data_memory_unit: RTL
=====================

Name: data_memory_unit

Overview:
Parametrised byte-addressable data memory for the RV32 load/store stage; successor to the flat word-indexed data memory. Supports LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension, byte-lane stores and error detection. Uses a valid/ready request and response handshake with a configurable response latency. Sits between the execute/memory stage and the writeback mux.

Parameters:
XLEN, 32, data and address width; only 32 is supported.
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2, 16 to 65536.
READ_LATENCY, 1, cycles from accept edge to the first response-cycle edge; legal range 1 to 4.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address
req_funct3  input  3  RISC-V load/store funct3
req_wdata  input  XLEN  store data, right-aligned
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  XLEN  extended load data; 0 for stores and errors
resp_err  output  1  access error, qualified by resp_valid

Behaviour:
- Reset (synchronous, active-high, sampled at rising edge): req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE, latency counter=0.
  - Memory array is zero-initialised at time 0 and is not cleared by reset.
- Accept: at a rising edge with req_valid && req_ready.
  - All request fields are sampled at that edge (edge k).
  - Only one request may be outstanding.
- FSM:
  - IDLE: req_ready=1. On accept, go to WAIT with counter = READ_LATENCY-1, or go straight to RESP when READ_LATENCY=1.
  - WAIT: req_ready=0. Decrement the counter each edge; go to RESP when the counter reaches 0.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle, then IDLE.
- Timing:
  - resp_valid is high in the cycle following edge k+READ_LATENCY-1.
  - req_ready returns to 1 in the cycle after the RESP cycle.
  - Maximum throughput is one access per READ_LATENCY+1 cycles.
- Commit point: stores write the array at accept edge k. Loads read the array at edge k, and the result is held in a data register until RESP. Read-after-write across back-to-back requests therefore always returns the new data.
- Address decode: word index = req_addr[31:2], byte offset = req_addr[1:0].
- Loads:
  - funct3 000 LB / 100 LBU: byte at the offset, sign- or zero-extended.
  - funct3 001 LH / 101 LHU: halfword at offset[1], sign- or zero-extended.
  - funct3 010 LW: full word.
- Stores:
  - funct3 000 SB: write req_wdata[7:0] to byte lane offset.
  - funct3 001 SH: write req_wdata[15:0] to lanes {offset[1],0} and {offset[1],1}.
  - funct3 010 SW: write all 4 lanes.
  - Unwritten lanes keep their contents.
- Errors (resp_err=1, resp_rdata=0, no array write):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - Load funct3 in {011, 110, 111}.
  - Store funct3 with bit2=1 or equal to 011.
  - An erroring request still completes the full handshake with normal latency.
- Stores without error: resp_valid=1, resp_err=0, resp_rdata=0.
- Outputs resp_rdata and resp_err are held at 0 whenever resp_valid=0.
- Reset mid-operation: FSM returns to IDLE and any pending response is dropped. A store accepted before reset stays committed; a pending load result is discarded.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.

Test Plan:
1. READ_LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store response resp_valid one cycle after its accept, err=0, rdata=0. Load response rdata=0xDEADBEEF, with req_ready low during each response cycle.
2. SB 0x13 data 0x80, then LB 0x13 -> rdata=0xFFFFFF80. Then LBU 0x13 -> 0x00000080. Then LW 0x10 -> 0x80ADBEEF.
3. SH 0x22 data 0x1234; LH 0x22 -> 0x00001234. Then LH 0x21 -> resp_err=1, rdata=0, and memory is unchanged.
4. READ_LATENCY=3: LW at accept edge k -> resp_valid high only in the cycle after edge k+2. req_valid held high throughout is not accepted again until req_ready returns one cycle after RESP.
5. DEPTH_WORDS=16: SW to 0x40 -> resp_err=1; a subsequent LW 0x0 returns 0 (no aliasing write). Load funct3=011 -> resp_err=1.
6. READ_LATENCY=2: assert reset in the WAIT cycle after LW accept -> no resp_valid, req_ready=1 the cycle after the reset edge. A store accepted before reset reads back its written data.

Source files
------------

// File: rtl/data_memory_unit.sv
// Byte-addressable RV32 data memory with valid/ready request/response handshake.
// Stores commit at the accept edge; load data is captured at accept and returned after READ_LATENCY.
module data_memory_unit #(
    parameter int XLEN         = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [1:0]      dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Handshake: a request is accepted at a rising edge where req_valid && req_ready
    // (and reset is low); the response is a single-cycle resp_valid strobe with
    // resp_rdata/resp_err qualified by it. Only one request is ever outstanding.

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   mem [DEPTH_WORDS] = '{default: '0};

    logic              accept;
    logic [IDX_W-1:0]  word_idx;
    logic [1:0]        byte_off;
    logic              out_of_range;
    logic              misaligned;
    logic              bad_funct3;
    logic              access_err;
    logic [XLEN-1:0]   rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;
    logic [3:0]        byte_en;

    assign accept       = req_valid && req_ready && !reset;
    assign word_idx     = req_addr[IDX_W+1:2];
    assign byte_off     = req_addr[1:0];
    assign out_of_range = |req_addr[XLEN-1:IDX_W+2];
    assign rd_word      = mem[word_idx];

    // Size/alignment checks share funct3[1:0]; bit 2 is only legal for LBU/LHU.
    always_comb begin
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (req_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = byte_off[0];
            2'b10:   misaligned = |byte_off;
            default: bad_funct3 = 1'b1;
        endcase
        if (req_we ? req_funct3[2] : (req_funct3[2] && req_funct3[1])) begin
            bad_funct3 = 1'b1;
        end
    end

    assign access_err = out_of_range || misaligned || bad_funct3;

    always_comb begin
        ld_byte   = rd_word[{byte_off, 3'b000} +: 8];
        ld_half   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (req_funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            3'b010:  load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        store_data = req_wdata;
        byte_en    = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                store_data = {4{req_wdata[7:0]}};
                byte_en    = 4'b0001 << byte_off;
            end
            2'b01: begin
                store_data = {2{req_wdata[15:0]}};
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                store_data = req_wdata;
                byte_en    = 4'b1111;
            end
            default: begin
                store_data = req_wdata;
                byte_en    = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            rdata_d = (access_err || req_we) ? '0 : load_data;
            err_d   = access_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // WAIT leaves for RESP on the edge where the counter would reach zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (READ_LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 3'(READ_LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid ? err_q : 1'b0;
        dbg_state  = state_q;
    end

endmodule
